// File: rtl/pipe_adder_pkg.sv
// Shared constants and parameter-legality helper for the segmented pipelined adder.
package pipe_adder_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;

   // A legal configuration splits the word into equal, non-empty carry segments.
   function automatic bit params_legal(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// One carry segment of the pipelined adder: a SEG-bit combinational add with carry in/out.
module adder_seg
   import pipe_adder_pkg::*;
#(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Carry-segmented pipelined adder with global valid/ready stall.
// Optional two's-complement overflow output enabled by the ADDER_OVF_EN macro.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int SEG  = (STAGES > 0) ? (WIDTH / STAGES) : 1;
   localparam int LAST = STAGES - 1;

   if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
      $fatal(1, "pipe_adder: WIDTH must be a positive multiple of STAGES");
   end

`ifdef ADDER_OVF_EN
   function automatic logic ovf_of(input logic sa, input logic sb, input logic ss);
      return (sa == sb) && (ss != sa);
   endfunction
`endif

   logic             en;
   logic [LAST:0]    vld_p;
   logic [WIDTH-1:0] a_p   [STAGES];
   logic [WIDTH-1:0] b_p   [STAGES];
   logic [WIDTH-1:0] sum_p [STAGES];
   logic             c_p   [STAGES];
   logic [SEG-1:0]   seg_sum [STAGES];
   logic             seg_co  [STAGES];

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Stage g adds operand segment g; stage 0 sees the live inputs, later stages the skewed copies.
   for (genvar g = 0; g < STAGES; g++) begin : g_seg
      logic [SEG-1:0] op_a;
      logic [SEG-1:0] op_b;
      logic           c_in;

      if (g == 0) begin : g_first
         assign op_a = a[SEG-1:0];
         assign op_b = b[SEG-1:0];
         assign c_in = cin;
      end else begin : g_rest
         assign op_a = a_p[g-1][g*SEG +: SEG];
         assign op_b = b_p[g-1][g*SEG +: SEG];
         assign c_in = c_p[g-1];
      end

      adder_seg #(.SEG(SEG)) u_seg (
         .a    (op_a),
         .b    (op_b),
         .cin  (c_in),
         .sum  (seg_sum[g]),
         .cout (seg_co[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else if (en) begin
         vld_p[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            vld_p[k] <= vld_p[k-1];
         end
      end
   end

   // Data registers carry no reset; anything behind a cleared valid bit is a bubble.
   always_ff @(posedge clk) begin
      if (en) begin
         a_p[0]   <= a;
         b_p[0]   <= b;
         c_p[0]   <= seg_co[0];
         sum_p[0] <= WIDTH'(seg_sum[0]);
         for (int k = 1; k < STAGES; k++) begin
            a_p[k]                  <= a_p[k-1];
            b_p[k]                  <= b_p[k-1];
            c_p[k]                  <= seg_co[k];
            sum_p[k]                <= sum_p[k-1];
            sum_p[k][k*SEG +: SEG]  <= seg_sum[k];
         end
      end
   end

   // Outputs read zero whenever no result is presented, including right after reset.
   assign out_valid = vld_p[LAST];
   assign sum       = out_valid ? sum_p[LAST] : '0;
   assign cout      = out_valid && c_p[LAST];

`ifdef ADDER_OVF_EN
   assign ovf = out_valid && ovf_of(a_p[LAST][WIDTH-1], b_p[LAST][WIDTH-1], sum_p[LAST][WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed 32/4 scenarios plus randomized 16/1, 32/4, 64/8 traffic
// scored against an arithmetic reference queue per instance.
module tb_pipe_adder;

`ifdef ADDER_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        iv16, ir16, c16, ov16, or16, co16, ovf16;
   logic [15:0] a16, b16, s16;
   logic        iv32, ir32, c32, ov32, or32, co32, ovf32;
   logic [31:0] a32, b32, s32;
   logic        iv64, ir64, c64, ov64, or64, co64, ovf64;
   logic [63:0] a64, b64, s64;

   pipe_adder #(.WIDTH(16), .STAGES(1)) u16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(c16),
      .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
`ifdef ADDER_OVF_EN
      , .ovf(ovf16)
`endif
   );

   pipe_adder #(.WIDTH(32), .STAGES(4)) u32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(c32),
      .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32)
`ifdef ADDER_OVF_EN
      , .ovf(ovf32)
`endif
   );

   pipe_adder #(.WIDTH(64), .STAGES(8)) u64 (
      .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .cin(c64),
      .out_valid(ov64), .out_ready(or64), .sum(s64), .cout(co64)
`ifdef ADDER_OVF_EN
      , .ovf(ovf64)
`endif
   );

`ifndef ADDER_OVF_EN
   assign ovf16 = 1'b0;
   assign ovf32 = 1'b0;
   assign ovf64 = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [65:0] q    [3][$];
   logic        held [3];
   logic [65:0] hval [3];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // True signed overflow of a+b+cin at width w, computed on wide signed integers.
   function automatic logic ref_ovf(input logic [63:0] a, input logic [63:0] b, input logic c, input int w);
      logic signed [67:0] sa, sb, t, lim;
      sa = $signed({4'b0, a});
      sb = $signed({4'b0, b});
      if (a[w-1]) sa = sa - (68'sd1 <<< w);
      if (b[w-1]) sb = sb - (68'sd1 <<< w);
      t   = sa + sb + $signed({67'b0, c});
      lim = 68'sd1 <<< (w - 1);
      return (t >= lim) || (t < -lim);
   endfunction

   function automatic logic [65:0] mk_exp(input logic [63:0] a, input logic [63:0] b, input logic c, input int w);
      logic [64:0] t;
      t = 65'(a) + 65'(b) + 65'(c);
      return {OVF_ON ? ref_ovf(a, b, c, w) : 1'b0, t};
   endfunction

   task automatic score(input int id, input string tag, input logic acc, input logic [65:0] exp,
                        input logic ov, input logic rdy, input logic [65:0] obs);
      if (held[id]) chk({tag, " hold"}, {ov, obs}, {1'b1, hval[id]});
      if (ov && rdy) begin
         chk({tag, " pop"}, q[id].size() != 0, 1'b1);
         if (q[id].size() != 0) chk({tag, " result"}, obs, q[id].pop_front());
      end
      if (acc) q[id].push_back(exp);
      held[id] = ov && !rdy;
      hval[id] = obs;
   endtask

   // Inputs are set at posedge+1; handshakes are scored at posedge+2, then one edge is taken.
   task automatic step();
      #1;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            q[i].delete();
            held[i] = 1'b0;
         end
      end else begin
         score(0, "u16", iv16 && ir16, mk_exp(64'(a16), 64'(b16), c16, 16), ov16, or16, {ovf16, 65'({co16, s16})});
         score(1, "u32", iv32 && ir32, mk_exp(64'(a32), 64'(b32), c32, 32), ov32, or32, {ovf32, 65'({co32, s32})});
         score(2, "u64", iv64 && ir64, mk_exp(a64, b64, c64, 64), ov64, or64, {ovf64, 65'({co64, s64})});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic xfer32(input logic [31:0] a, input logic [31:0] b, input logic c, output int lat);
      a32 = a; b32 = b; c32 = c; iv32 = 1'b1;
      step();
      iv32 = 1'b0;
      lat = 1;
      while (!ov32 && lat <= 12) begin
         step();
         lat++;
      end
   endtask

   task automatic rand32();
      a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
   endtask

   initial begin
      int lat, cnt, first, last, seen;
      for (int i = 0; i < 3; i++) held[i] = 1'b0;
      rst = 1'b1;
      iv16 = 0; iv32 = 0; iv64 = 0; or16 = 1; or32 = 1; or64 = 1;
      a16 = 0; b16 = 0; c16 = 0; a32 = 0; b32 = 0; c32 = 0; a64 = 0; b64 = 0; c64 = 0;
      @(posedge clk); #1;
      step();
      step();
      rst = 1'b0;
      chk("reset out_valid", {ov16, ov32, ov64}, 3'b000);
      chk("reset sum32", s32, 32'h0);
      chk("reset cout32", co32, 1'b0);
      chk("reset ovf32", ovf32, 1'b0);
      chk("reset in_ready", {ir16, ir32, ir64}, 3'b111);

      xfer32(32'h0000_0001, 32'h0000_0002, 1'b0, lat);
      chk("latency 1+2", lat, 4);
      chk("sum 1+2", {co32, s32}, 33'h0_0000_0003);

      xfer32(32'hFFFF_FFFF, 32'h0, 1'b1, lat);
      chk("latency ripple", lat, 4);
      chk("ripple sum/cout", {co32, s32}, 33'h1_0000_0000);
      if (OVF_ON) chk("ripple ovf", ovf32, 1'b0);

      xfer32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
      chk("max+1 sum/cout", {co32, s32}, 33'h0_8000_0000);
      if (OVF_ON) chk("max+1 ovf", ovf32, 1'b1);

      // Eight back-to-back transfers must come out as eight consecutive valid cycles.
      cnt = 0; first = -1; last = -1;
      for (int i = 0; i < 20; i++) begin
         iv32 = (i < 8);
         rand32();
         step();
         if (ov32) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      iv32 = 1'b0;
      chk("b2b count", cnt, 8);
      chk("b2b contiguous", last - first, 7);

      // Fill the pipe with the output blocked, hold five cycles, then release.
      or32 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         iv32 = 1'b1; rand32();
         step();
      end
      for (int i = 0; i < 5; i++) begin
         iv32 = 1'b1; rand32();
         step();
         chk("stall in_ready", ir32, 1'b0);
         chk("stall out_valid", ov32, 1'b1);
      end
      or32 = 1'b1; iv32 = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("stall drained", q[1].size(), 0);

      // Reset with three transfers in flight: nothing may emerge afterwards.
      for (int i = 0; i < 3; i++) begin
         iv32 = 1'b1; rand32();
         step();
      end
      iv32 = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst out_valid", ov32, 1'b0);
      chk("midrst sum/cout", {co32, s32}, 33'h0);
      chk("midrst in_ready", ir32, 1'b1);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ov32) seen++;
      end
      chk("midrst stale", seen, 0);

      // Full-width ripple on the degenerate and deep configurations.
      a16 = 16'hFFFF; b16 = 16'h0; c16 = 1'b1; iv16 = 1'b1;
      a64 = '1;       b64 = 64'h0; c64 = 1'b1; iv64 = 1'b1;
      step();
      a16 = 16'h7FFF; b16 = 16'h0001; c16 = 1'b0;
      a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'h1; c64 = 1'b0;
      step();
      iv16 = 1'b0; iv64 = 1'b0;
      for (int i = 0; i < 12; i++) step();
      chk("ripple16/64 drained", q[0].size() + q[2].size(), 0);

      // Random operands with random valid/ready stalls on all three configurations.
      for (int n = 0; n < 400; n++) begin
         iv16 = ($urandom_range(0, 3) != 0); or16 = ($urandom_range(0, 3) != 0);
         iv32 = ($urandom_range(0, 3) != 0); or32 = ($urandom_range(0, 3) != 0);
         iv64 = ($urandom_range(0, 3) != 0); or64 = ($urandom_range(0, 3) != 0);
         a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
         rand32();
         a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; c64 = 1'($urandom);
         step();
      end
      iv16 = 0; iv32 = 0; iv64 = 0; or16 = 1; or32 = 1; or64 = 1;
      for (int i = 0; i < 20; i++) step();
      chk("final drain u16", q[0].size(), 0);
      chk("final drain u32", q[1].size(), 0);
      chk("final drain u64", q[2].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
